// File: rtl/marker_pkg.sv
// marker_pkg: shared pixel/distance widths, ring colours and radius-FSM states for draw_targets
package marker_pkg;
    localparam int SCREEN_WIDTH_DEF  = 1280;
    localparam int SCREEN_HEIGHT_DEF = 720;
    localparam int HW   = $clog2(SCREEN_WIDTH_DEF) + 1;
    localparam int VW   = $clog2(SCREEN_HEIGHT_DEF) + 1;
    localparam int DSQW = 2 * HW + 1;
    localparam logic [2:0] RING_EVEN = 3'b000;
    localparam logic [2:0] RING_ODD  = 3'b111;
    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_COMPUTE} calc_state_e;
endpackage

// File: rtl/ring_radii_calc.sv
// ring_radii_calc: snapshots the target list at frame start, computes squared ring radii with one
// shared multiplier and commits the whole active set at once.
// Ports: clk_in/rst_in clock and sync reset; start_in frame-start strobe; xcount_in/ycount_in/
// diameter_in/valid_in live target arrays; act_*_out committed active set (act_rsq_out[t][k-1] is
// ring k); busy_out high during LATCH and COMPUTE.
module ring_radii_calc
    import marker_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int NUM_RINGS   = 4,
    parameter int XW          = HW,
    parameter int YW          = VW,
    parameter int SW          = DSQW
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic                                        start_in,
    input  logic [NUM_TARGETS-1:0][XW-1:0]              xcount_in,
    input  logic [NUM_TARGETS-1:0][YW-1:0]              ycount_in,
    input  logic [NUM_TARGETS-1:0][YW-1:0]              diameter_in,
    input  logic [NUM_TARGETS-1:0]                      valid_in,
    output logic [NUM_TARGETS-1:0][XW-1:0]              act_x_out,
    output logic [NUM_TARGETS-1:0][YW-1:0]              act_y_out,
    output logic [NUM_TARGETS-1:0]                      act_valid_out,
    output logic [NUM_TARGETS-1:0][NUM_RINGS-1:0][SW-1:0] act_rsq_out,
    output logic                                        busy_out
);
    localparam int TW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
    localparam int KW = NUM_RINGS > 1 ? $clog2(NUM_RINGS) : 1;
    localparam int SH = $clog2(2 * NUM_RINGS);
    localparam int PW = YW + KW + 1;

    calc_state_e state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [KW-1:0] k_q, k_d;
    logic [NUM_TARGETS-1:0][XW-1:0] sh_x_q, sh_x_d, act_x_q, act_x_d;
    logic [NUM_TARGETS-1:0][YW-1:0] sh_y_q, sh_y_d, act_y_q, act_y_d, sh_dia_q, sh_dia_d;
    logic [NUM_TARGETS-1:0] sh_valid_q, sh_valid_d, act_valid_q, act_valid_d;
    logic [NUM_TARGETS-1:0][NUM_RINGS-1:0][SW-1:0] sh_rsq_q, sh_rsq_d, act_rsq_q, act_rsq_d;
    logic [PW-1:0] prod;
    logic [YW-1:0] r;
    logic [SW-1:0] rsq;
    logic k_last, last;

    always_comb begin
        // k_q holds k-1, so the multiplier sees k = k_q + 1
        prod        = PW'(sh_dia_q[t_q]) * PW'({1'b0, k_q} + (KW+1)'(1));
        r           = YW'(prod >> SH);
        rsq         = SW'(r) * SW'(r);
        k_last      = k_q == KW'(NUM_RINGS - 1);
        last        = k_last && (t_q == TW'(NUM_TARGETS - 1));
        state_d     = state_q;
        t_d         = t_q;
        k_d         = k_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        sh_dia_d    = sh_dia_q;
        sh_valid_d  = sh_valid_q;
        sh_rsq_d    = sh_rsq_q;
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        act_valid_d = act_valid_q;
        act_rsq_d   = act_rsq_q;
        if (state_q == ST_IDLE && start_in) state_d = ST_LATCH;
        if (state_q == ST_LATCH) begin
            sh_x_d     = xcount_in;
            sh_y_d     = ycount_in;
            sh_dia_d   = diameter_in;
            sh_valid_d = valid_in;
            t_d        = '0;
            k_d        = '0;
            state_d    = ST_COMPUTE;
        end
        if (state_q == ST_COMPUTE) begin
            sh_rsq_d[t_q][k_q] = rsq;
            k_d = k_last ? '0 : k_q + KW'(1);
            t_d = k_last ? t_q + TW'(1) : t_q;
            // commit includes the radius produced in this final cycle
            if (last) begin
                act_x_d     = sh_x_q;
                act_y_d     = sh_y_q;
                act_valid_d = sh_valid_q;
                act_rsq_d   = sh_rsq_d;
                state_d     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            k_q         <= '0;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sh_dia_q    <= '0;
            sh_valid_q  <= '0;
            sh_rsq_q    <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_valid_q <= '0;
            act_rsq_q   <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            k_q         <= k_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_dia_q    <= sh_dia_d;
            sh_valid_q  <= sh_valid_d;
            sh_rsq_q    <= sh_rsq_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_valid_q <= act_valid_d;
            act_rsq_q   <= act_rsq_d;
        end
    end

    assign act_x_out     = act_x_q;
    assign act_y_out     = act_y_q;
    assign act_valid_out = act_valid_q;
    assign act_rsq_out   = act_rsq_q;
    assign busy_out      = state_q != ST_IDLE;
endmodule

// File: rtl/draw_targets.sv
// draw_targets: overlays concentric black/white ring markers for each active target onto the video
// stream through a fixed 3-cycle pipeline.
// Ports: clk_in/rst_in pixel clock and sync reset; hcount_in/vcount_in/rgb_in incoming pixel;
// xcount_in/ycount_in/diameter_in/valid_in per-target arrays; hcount_out/vcount_out/rgb_out pixel
// delayed 3 cycles with overlay; busy_out high while ring radii are being recomputed.
module draw_targets
    import marker_pkg::*;
#(
    parameter int NUM_TARGETS   = 4,
    parameter int NUM_RINGS     = 4,
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
    input  logic                                                   clk_in,
    input  logic                                                   rst_in,
    input  logic [$clog2(SCREEN_WIDTH):0]                          hcount_in,
    input  logic [$clog2(SCREEN_HEIGHT):0]                         vcount_in,
    input  logic [2:0]                                             rgb_in,
    input  logic [NUM_TARGETS-1:0][$clog2(SCREEN_WIDTH):0]         xcount_in,
    input  logic [NUM_TARGETS-1:0][$clog2(SCREEN_HEIGHT):0]        ycount_in,
    input  logic [NUM_TARGETS-1:0][$clog2(SCREEN_HEIGHT):0]        diameter_in,
    input  logic [NUM_TARGETS-1:0]                                 valid_in,
    output logic [$clog2(SCREEN_WIDTH):0]                          hcount_out,
    output logic [$clog2(SCREEN_HEIGHT):0]                         vcount_out,
    output logic [2:0]                                             rgb_out,
    output logic                                                   busy_out
);
    localparam int XW = $clog2(SCREEN_WIDTH) + 1;
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
    localparam int SW = 2 * XW + 1;

    logic frame_start;
    logic [NUM_TARGETS-1:0][XW-1:0] act_x;
    logic [NUM_TARGETS-1:0][YW-1:0] act_y;
    logic [NUM_TARGETS-1:0] act_valid;
    logic [NUM_TARGETS-1:0][NUM_RINGS-1:0][SW-1:0] act_rsq;
    logic [NUM_TARGETS-1:0][XW-1:0] s1_dx_q, s1_dx_d;
    logic [NUM_TARGETS-1:0][YW-1:0] s1_dy_q, s1_dy_d;
    logic [NUM_TARGETS-1:0][SW-1:0] s2_dsq_q, s2_dsq_d;
    logic [XW-1:0] s1_h_q, s2_h_q, hout_q;
    logic [YW-1:0] s1_v_q, s2_v_q, vout_q;
    logic [2:0] s1_rgb_q, s2_rgb_q, rgb_q, rgb_d;
    logic par;

    assign frame_start = (vcount_in == YW'(SCREEN_HEIGHT)) && (hcount_in == '0);

    ring_radii_calc #(
        .NUM_TARGETS(NUM_TARGETS),
        .NUM_RINGS  (NUM_RINGS),
        .XW         (XW),
        .YW         (YW),
        .SW         (SW)
    ) u_calc (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (frame_start),
        .xcount_in    (xcount_in),
        .ycount_in    (ycount_in),
        .diameter_in  (diameter_in),
        .valid_in     (valid_in),
        .act_x_out    (act_x),
        .act_y_out    (act_y),
        .act_valid_out(act_valid),
        .act_rsq_out  (act_rsq),
        .busy_out     (busy_out)
    );

    always_comb begin
        rgb_d = s2_rgb_q;
        par   = 1'b0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            s1_dx_d[t]  = (hcount_in >= act_x[t]) ? hcount_in - act_x[t] : act_x[t] - hcount_in;
            s1_dy_d[t]  = (vcount_in >= act_y[t]) ? vcount_in - act_y[t] : act_y[t] - vcount_in;
            s2_dsq_d[t] = SW'(s1_dx_q[t]) * SW'(s1_dx_q[t]) + SW'(s1_dy_q[t]) * SW'(s1_dy_q[t]);
        end
        // walk from the highest slot down so the lowest-index hit overrides
        for (int t = NUM_TARGETS - 1; t >= 0; t--) begin
            par = 1'b0;
            for (int k = 0; k < NUM_RINGS; k++) par = par ^ (act_rsq[t][k] <= s2_dsq_q[t]);
            if (act_valid[t] && s2_dsq_q[t] < act_rsq[t][NUM_RINGS-1]) rgb_d = par ? RING_ODD : RING_EVEN;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_dx_q  <= '0;
            s1_dy_q  <= '0;
            s2_dsq_q <= '0;
            s1_h_q   <= '0;
            s2_h_q   <= '0;
            hout_q   <= '0;
            s1_v_q   <= '0;
            s2_v_q   <= '0;
            vout_q   <= '0;
            s1_rgb_q <= '0;
            s2_rgb_q <= '0;
            rgb_q    <= '0;
        end else begin
            s1_dx_q  <= s1_dx_d;
            s1_dy_q  <= s1_dy_d;
            s2_dsq_q <= s2_dsq_d;
            s1_h_q   <= hcount_in;
            s2_h_q   <= s1_h_q;
            hout_q   <= s2_h_q;
            s1_v_q   <= vcount_in;
            s2_v_q   <= s1_v_q;
            vout_q   <= s2_v_q;
            s1_rgb_q <= rgb_in;
            s2_rgb_q <= s1_rgb_q;
            rgb_q    <= rgb_d;
        end
    end

    assign hcount_out = hout_q;
    assign vcount_out = vout_q;
    assign rgb_out    = rgb_q;
endmodule

// File: tb/tb_draw_targets.sv
// tb_draw_targets: scenario tasks for draw_targets checked against an arithmetic ring model
module tb_draw_targets;
    import marker_pkg::*;
    localparam int NT = 4;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [HW-1:0] hcount = '0;
    logic [VW-1:0] vcount = '0;
    logic [2:0] rgb = '0;
    logic [NT-1:0][HW-1:0] xin = '0;
    logic [NT-1:0][VW-1:0] yin = '0;
    logic [NT-1:0][VW-1:0] din = '0;
    logic [NT-1:0] vin = '0;
    logic [HW-1:0] hout;
    logic [VW-1:0] vout;
    logic [2:0] rgb_o;
    logic busy;
    int checks = 0;
    int errors = 0;
    int m_x[NT], m_y[NT], m_d[NT];
    bit m_v[NT];

    always #5 clk = ~clk;

    draw_targets #(.NUM_TARGETS(NT), .NUM_RINGS(NR), .SCREEN_WIDTH(1280), .SCREEN_HEIGHT(720)) dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount), .rgb_in(rgb),
        .xcount_in(xin), .ycount_in(yin), .diameter_in(din), .valid_in(vin),
        .hcount_out(hout), .vcount_out(vout), .rgb_out(rgb_o), .busy_out(busy)
    );

    function automatic int radius(int d, int k);
        return (d * k) / (2 * NR);
    endfunction

    function automatic logic [2:0] model_rgb(int h, int v, logic [2:0] bg);
        for (int t = 0; t < NT; t++) begin
            int dsq, ring, outer;
            dsq = (h - m_x[t]) * (h - m_x[t]) + (v - m_y[t]) * (v - m_y[t]);
            outer = radius(m_d[t], NR);
            ring = 0;
            if (m_v[t] && dsq < outer * outer) begin
                for (int k = 1; k <= NR; k++) if (radius(m_d[t], k) * radius(m_d[t], k) <= dsq) ring++;
                return (ring % 2) ? 3'b111 : 3'b000;
            end
        end
        return bg;
    endfunction

    function automatic int clamp(int a, int lo, int hi);
        return a < lo ? lo : (a > hi ? hi : a);
    endfunction

    task automatic model_clear();
        for (int t = 0; t < NT; t++) m_v[t] = 1'b0;
    endtask

    task automatic set_target(input int t, input int x, input int y, input int d, input bit v);
        xin[t] = HW'(x);
        yin[t] = VW'(y);
        din[t] = VW'(d);
        vin[t] = v;
    endtask

    task automatic sample_pixel(input int h, input int v, input logic [2:0] c,
                                output logic [2:0] got, output int gh, output int gv);
        hcount = HW'(h);
        vcount = VW'(v);
        rgb = c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = rgb_o;
        gh = int'(hout);
        gv = int'(vout);
        @(posedge clk);
        #1;
    endtask

    task automatic run_blanking(output int cnt);
        vcount = VW'(720);
        hcount = '0;
        @(posedge clk);
        #1 hcount = HW'(1);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        for (int t = 0; t < NT; t++) begin
            m_x[t] = int'(xin[t]);
            m_y[t] = int'(yin[t]);
            m_d[t] = int'(din[t]);
            m_v[t] = vin[t];
        end
    endtask

    task automatic test_reset();
        logic [2:0] got;
        int gh, gv, cnt;
        rst = 1'b1;
        hcount = HW'(5);
        vcount = VW'(7);
        rgb = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rgb_o !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b expected 000", rgb_o); end
        checks++; if (hout !== '0) begin errors++; $display("FAIL reset_hcount: got %0d expected 0", hout); end
        checks++; if (vout !== '0) begin errors++; $display("FAIL reset_vcount: got %0d expected 0", vout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        sample_pixel(10, 10, 3'b101, got, gh, gv);
        checks++; if (got !== 3'b101) begin errors++; $display("FAIL idle_rgb: got %b expected 101", got); end
        checks++; if (gh != 10) begin errors++; $display("FAIL idle_hcount: got %0d expected 10", gh); end
        checks++; if (gv != 10) begin errors++; $display("FAIL idle_vcount: got %0d expected 10", gv); end
        run_blanking(cnt);
        checks++; if (cnt != 17) begin errors++; $display("FAIL busy_len: got %0d expected 17", cnt); end
    endtask

    task automatic test_single_target();
        int px[4] = '{100, 115, 139, 140};
        logic [2:0] exp_c[4] = '{3'b000, 3'b111, 3'b111, 3'b010};
        logic [2:0] got;
        int gh, gv, cnt;
        set_target(0, 100, 50, 80, 1'b1);
        run_blanking(cnt);
        checks++; if (cnt != 17) begin errors++; $display("FAIL single_busy: got %0d expected 17", cnt); end
        for (int i = 0; i < 4; i++) begin
            sample_pixel(px[i], 50, 3'b010, got, gh, gv);
            checks++;
            if (got !== exp_c[i]) begin
                errors++;
                $display("FAIL single_px(%0d,50): got %b expected %b", px[i], got, exp_c[i]);
            end
        end
    endtask

    task automatic test_hold_until_commit();
        logic [2:0] got;
        int gh, gv, cnt;
        xin[0] = HW'(300);
        sample_pixel(100, 50, 3'b011, got, gh, gv);
        checks++; if (got !== 3'b000) begin errors++; $display("FAIL hold_old(100,50): got %b expected 000", got); end
        sample_pixel(300, 50, 3'b011, got, gh, gv);
        checks++; if (got !== 3'b011) begin errors++; $display("FAIL hold_new(300,50): got %b expected 011", got); end
        run_blanking(cnt);
        checks++; if (cnt != 17) begin errors++; $display("FAIL hold_busy: got %0d expected 17", cnt); end
        sample_pixel(300, 50, 3'b011, got, gh, gv);
        checks++; if (got !== 3'b000) begin errors++; $display("FAIL moved_new(300,50): got %b expected 000", got); end
        sample_pixel(100, 50, 3'b011, got, gh, gv);
        checks++; if (got !== 3'b011) begin errors++; $display("FAIL moved_old(100,50): got %b expected 011", got); end
    endtask

    task automatic test_overlap();
        logic [2:0] got;
        int gh, gv, cnt;
        set_target(0, 200, 200, 80, 1'b1);
        set_target(1, 200, 200, 40, 1'b1);
        run_blanking(cnt);
        checks++; if (cnt != 17) begin errors++; $display("FAIL overlap_busy: got %0d expected 17", cnt); end
        sample_pixel(225, 200, 3'b001, got, gh, gv);
        checks++; if (got !== 3'b000) begin errors++; $display("FAIL overlap(225,200): got %b expected 000", got); end
        sample_pixel(210, 200, 3'b001, got, gh, gv);
        checks++; if (got !== 3'b111) begin errors++; $display("FAIL overlap(210,200): got %b expected 111", got); end
    endtask

    task automatic test_no_draw();
        logic [2:0] got;
        int gh, gv, cnt;
        int ph[3] = '{400, 600, 615};
        set_target(0, 400, 300, 0, 1'b1);
        set_target(1, 600, 300, 80, 1'b0);
        run_blanking(cnt);
        checks++; if (cnt != 17) begin errors++; $display("FAIL nodraw_busy: got %0d expected 17", cnt); end
        for (int i = 0; i < 3; i++) begin
            sample_pixel(ph[i], 300, 3'b110, got, gh, gv);
            checks++;
            if (got !== 3'b110) begin errors++; $display("FAIL nodraw(%0d,300): got %b expected 110", ph[i], got); end
        end
    endtask

    task automatic test_reset_mid_compute();
        logic [2:0] got;
        int gh, gv, cnt;
        vin = '0;
        set_target(0, 100, 50, 80, 1'b1);
        vcount = VW'(720);
        hcount = '0;
        @(posedge clk);
        #1 hcount = HW'(1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_after: got %b expected 0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        sample_pixel(100, 50, 3'b101, got, gh, gv);
        checks++; if (got !== 3'b101) begin errors++; $display("FAIL midreset_nodraw: got %b expected 101", got); end
        run_blanking(cnt);
        checks++; if (cnt != 17) begin errors++; $display("FAIL midreset_busy: got %0d expected 17", cnt); end
        sample_pixel(100, 50, 3'b101, got, gh, gv);
        checks++; if (got !== 3'b000) begin errors++; $display("FAIL midreset_redraw: got %b expected 000", got); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_c[$];
        int exp_h[$], exp_v[$];
        int cnt, t, h, v, n;
        logic [2:0] c, ec;
        int eh, ev;
        n = 120;
        for (int round = 0; round < 3; round++) begin
            for (int s = 0; s < NT; s++)
                set_target(s, int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)),
                           int'($urandom_range(0, 200)), $urandom_range(0, 3) != 0);
            run_blanking(cnt);
            checks++; if (cnt != 17) begin errors++; $display("FAIL b2b_busy: got %0d expected 17", cnt); end
            for (int i = 0; i < n + 3; i++) begin
                if (i < n) begin
                    t = int'($urandom_range(0, NT - 1));
                    h = clamp(m_x[t] + int'($urandom_range(0, 2 * m_d[t] + 10)) - (m_d[t] + 5), 0, 1279);
                    v = clamp(m_y[t] + int'($urandom_range(0, 2 * m_d[t] + 10)) - (m_d[t] + 5), 0, 719);
                    c = 3'($urandom_range(0, 7));
                    hcount = HW'(h);
                    vcount = VW'(v);
                    rgb = c;
                    exp_c.push_back(model_rgb(h, v, c));
                    exp_h.push_back(h);
                    exp_v.push_back(v);
                end
                @(negedge clk);
                if (i >= 3) begin
                    ec = exp_c.pop_front();
                    eh = exp_h.pop_front();
                    ev = exp_v.pop_front();
                    checks++; if (rgb_o !== ec) begin errors++; $display("FAIL b2b_rgb(%0d,%0d): got %b expected %b", eh, ev, rgb_o, ec); end
                    checks++; if (int'(hout) != eh) begin errors++; $display("FAIL b2b_hcount: got %0d expected %0d", hout, eh); end
                    checks++; if (int'(vout) != ev) begin errors++; $display("FAIL b2b_vcount: got %0d expected %0d", vout, ev); end
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_target();
        test_hold_until_commit();
        test_overlap();
        test_no_draw();
        test_reset_mid_compute();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_targets.md
# draw_targets

Renders the current target list back into the video stream as concentric ring markers: the same ring pattern the marker detector searches for. It sits between the pixel generator and the video output. Each frame it takes a snapshot of the detector's per-target centre/diameter/valid arrays during vertical blanking and computes squared ring radii for every target with one shared multiplier. It then overlays alternating black/white rings on the background pixels through a fixed 3-cycle pipeline.

## Interface
- NUM_TARGETS, 4: number of target slots; power of two.
- NUM_RINGS, 4: rings per marker; power of two.
- SCREEN_WIDTH, 1280: active pixels per line.
- SCREEN_HEIGHT, 720: active lines per frame.
- clk_in  input  1  pixel clock; all state updates on its rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- hcount_in  input  $clog2(SCREEN_WIDTH)+1  current pixel column.
- vcount_in  input  $clog2(SCREEN_HEIGHT)+1  current pixel row.
- rgb_in  input  3  background pixel.
- xcount_in  input  $clog2(SCREEN_WIDTH)+1 x NUM_TARGETS  target centre column.
- ycount_in  input  $clog2(SCREEN_HEIGHT)+1 x NUM_TARGETS  target centre row.
- diameter_in  input  $clog2(SCREEN_HEIGHT)+1 x NUM_TARGETS  target diameter.
- valid_in  input  1 x NUM_TARGETS  target slot holds a marker.
- hcount_out, vcount_out  output  same as inputs  hcount_in and vcount_in delayed 3 cycles.
- rgb_out  output  3  overlaid pixel, aligned with hcount_out and vcount_out.
- busy_out  output  1  high while radii are being computed.

## Operation
- FSM with three states: IDLE, LATCH, COMPUTE.
  - IDLE -> LATCH when vcount_in==SCREEN_HEIGHT and hcount_in==0.
  - LATCH: for every slot t, copy xcount_in, ycount_in, diameter_in and valid_in into shadow registers. Go to COMPUTE with t=0, k=1.
  - COMPUTE: each cycle, r = (diameter[t]*k) >> log2(2*NUM_RINGS), and rsq_next[t][k] = r*r. Increment k; when k wraps past NUM_RINGS, increment t. After the last (t,k) pair, commit to the active set and return to IDLE.
  - Commit: active centres, active valids and active rsq are all loaded from the shadow registers together, in a single cycle.
- The frame-start condition seen during LATCH or COMPUTE is ignored.
- Pixel pipeline, using only the active set:
  - S1: dx = |hcount - x|, dy = |vcount - y| for each target.
  - S2: dsq = dx² + dy², width 2*($clog2(SCREEN_WIDTH)+1)+1.
  - S3: target t hits if active valid[t] is set and dsq < rsq[t][NUM_RINGS].
    - Ring index = number of k in 1..NUM_RINGS with rsq[t][k] <= dsq.
    - Lowest-index hitting target wins.
    - Colour: even ring index -> 3'b000; odd ring index -> 3'b111.
    - No hit -> rgb_in, delayed to match.
- All comparisons are strict "<" against the outer radius. A pixel exactly on a boundary belongs to the outer ring.
- diameter < 2*NUM_RINGS gives rsq[t][1]=0, so the innermost ring is empty. diameter==0 draws nothing.
- Reset: FSM to IDLE; shadow and active sets cleared; all valids 0; rgb_out=0, hcount_out=0, vcount_out=0, busy_out=0; pipeline registers cleared.
- Reset during COMPUTE abandons the computation. Nothing is committed.

## Timing
- Pixel latency is exactly 3 cycles. rgb_in at cycle N appears, overlaid or passed through, at rgb_out at cycle N+3.
- LATCH takes 1 cycle. COMPUTE takes NUM_TARGETS*NUM_RINGS cycles (16 at default parameters).
- busy_out is high from the LATCH cycle through the last COMPUTE cycle.
- The new active set takes effect at S3 on the cycle after the last COMPUTE cycle. Because that falls inside blanking, no visible frame ever mixes old and new targets.
- Input target arrays may change at any time. Only the values present at LATCH are used.

## Structure
- Package marker_pkg holds:
  - width localparams (HW, VW, DSQW);
  - colour constants RING_EVEN=3'b000, RING_ODD=3'b111;
  - the FSM state enum.
- Sub-module ring_radii_calc holds the LATCH/COMPUTE FSM, the shared multiplier, the shadow set and the commit. It drives the active arrays and busy_out.
- The top level holds the 3-stage pixel pipeline and the priority select.

## Test plan
- Reset, then idle pixels with rgb_in=3'b101 -> rgb_out=3'b101 three cycles later; busy_out high for exactly 17 cycles after the frame-start condition.
- Target 0: x=100, y=50, d=80, valid; run a blanking period -> rsq = 100, 400, 900, 1600. Expected pixels:
  - (100,50) -> 3'b000.
  - (115,50) -> 3'b111.
  - (139,50) -> 3'b111.
  - (140,50) -> rgb_in.
- Same target, but change xcount_in to 300 mid-frame -> markers stay at x=100 until the next blanking commit.
- Targets 0 and 1 overlapping, both at (200,200) with d=80 and d=40 -> pixel (225,200) coloured by target 0: dsq=625, ring 2 -> 3'b000.
- Target with d=0 or valid_in=0 -> no pixel is modified.
- rst_in asserted during the 8th COMPUTE cycle -> busy_out=0 next cycle and no markers drawn until the next full LATCH/COMPUTE.
